cmac_usplus_0_axis_multi_pkt_gen: RTL and testbench
===================================================

// Module: cmac_usplus_0_axis_multi_pkt_gen
// PURPOSE
//  Parametrised AXIS traffic generator feeding the CMAC TX AXIS port (txusrclk2 domain).
//  Successor to the single-size generator: multi-stream round-robin tagging, fixed or sweep
//  packet-size mode, per-stream sequence numbers, runtime stop, and sticky TX-error capture.
//  Sits between the exdes control logic and the CMAC TX AXIS interface.
// PARAMETERS
//  DATA_W      512   AXIS data width in bits; multiple of 64. BYTES = DATA_W/8.
//  PKT_NUM     1000  Packets per burst when continuous=0; valid range 1..65535.
//  MIN_SIZE    64    Minimum packet size in bytes. Also the clamp floor.
//  MAX_SIZE    1522  Maximum packet size in bytes (<=16000). Also the clamp ceiling and sweep top.
//  NUM_STREAMS 4     Number of stream IDs; valid range 1..256.
//  CNT_W       32    Width of the pkt_cnt output.
// PORTS
//  clk               in   1          TX user clock (txusrclk2)
//  reset             in   1          Asynchronous, active-high reset
//  start             in   1          Rising edge launches a burst (from IDLE or DONE only)
//  stop              in   1          Level. Finishes the current packet, then returns to IDLE
//  continuous        in   1          1 = ignore PKT_NUM and run until stop
//  size_mode         in   1          0 = fixed size, 1 = sweep MIN_SIZE..MAX_SIZE
//  fixed_size        in   14         Packet size in bytes for size_mode=0
//  link_up           in   1          TX link aligned / ready
//  tx_ovfout         in   1          CMAC overflow pulse
//  tx_unfout         in   1          CMAC underflow pulse
//  tx_axis_tready    in   1          AXIS ready
//  tx_axis_tvalid    out  1          AXIS valid
//  tx_axis_tdata     out  DATA_W     AXIS data
//  tx_axis_tkeep     out  DATA_W/8   AXIS byte enables
//  tx_axis_tlast     out  1          End of packet
//  tx_axis_tuser     out  1          Always 0; no error injection
//  busy              out  1          High in WAIT_LINK and SEND
//  done              out  1          High in DONE
//  tx_err            out  1          Sticky; set on tx_ovfout|tx_unfout, cleared by the start edge
//  pkt_cnt           out  CNT_W      Accepted packets (tlast & tvalid & tready); wraps; cleared by start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, size=MIN_SIZE, stream=0, all seq=0. Asynchronous assert.
//  FSM IDLE -> WAIT_LINK on start rising edge (start registered for edge detect).
//  WAIT_LINK -> SEND when link_up=1.
//  SEND -> DONE on accepting the tlast of packet PKT_NUM when continuous=0.
//  SEND -> IDLE on accepting a tlast while stop=1. stop has priority over DONE in the same cycle.
//  SEND -> WAIT_LINK on accepting a tlast while link_up=0.
//  DONE -> WAIT_LINK on start rising edge.
//  A packet in flight is never aborted by stop or link_up loss; it always completes.
//  Handshake: tvalid rises the cycle after SEND entry. tdata, tkeep and tlast are held stable while
//  tvalid & !tready. The next packet's first beat is presented the cycle after tlast is accepted
//  (no idle gap).
//  Size is latched at each packet start.
//   - Fixed mode: fixed_size is clamped to [MIN_SIZE, MAX_SIZE].
//   - Sweep mode: the first packet is MIN_SIZE; +1 per packet; after MAX_SIZE it wraps to MIN_SIZE.
//  Beats per packet = ceil(size/BYTES). Every beat except the last has tkeep all ones.
//  Last beat: tkeep = (1<<r)-1 with r = size - BYTES*(beats-1), where 1 <= r <= BYTES.
//  Byte k of a packet is placed in the tdata[8*(k%BYTES) +: 8] lane.
//   - Byte 0 = stream ID.
//   - Bytes 1,2 = that stream's 16-bit seq, big-endian.
//   - Byte k>=3 = k[7:0].
//  Stream ID is round-robin 0..NUM_STREAMS-1 per packet. The per-stream seq increments on that
//  stream's tlast acceptance and wraps at 65535.
//  If tx_err is set in the same cycle as the start edge, set wins.
//  Reset mid-packet: tvalid drops immediately (asynchronous); no partial resume.
// TESTING
//  fixed 64, PKT_NUM=3, tready=1 -> 3 single-beat packets, tlast every beat, tkeep=all ones,
//    byte0 = 0,1,2; pkt_cnt=3; done=1.
//  fixed 65 -> 2 beats; beat 2 tkeep=64'h1, tlast=1. fixed 10 -> clamped to 64.
//  sweep, MAX_SIZE=130, continuous=1 -> sizes 64,65..130,64; stream 0 seq increments once every
//    4 packets.
//  random tready backpressure for 500 packets -> no data change while stalled; byte pattern and
//    tkeep match the model; pkt_cnt=500.
//  link_up=0 mid-packet -> packet completes, FSM holds in WAIT_LINK with tvalid=0; link_up=1
//    resumes with the next seq.
//  reset asserted mid-packet -> outputs 0 the same cycle; tx_unfout pulse -> tx_err=1 until the
//    next start edge.

Source files
------------

// File: rtl/cmac_usplus_0_axis_multi_pkt_gen.sv
// rtl/cmac_usplus_0_axis_multi_pkt_gen.sv - multi-stream AXIS packet generator for the CMAC TX port
// Round-robin stream tagging, fixed/sweep packet sizes, per-stream sequence numbers, sticky TX errors.
module cmac_usplus_0_axis_multi_pkt_gen #(
    parameter int DATA_W      = 512,
    parameter int PKT_NUM     = 1000,
    parameter int MIN_SIZE    = 64,
    parameter int MAX_SIZE    = 1522,
    parameter int NUM_STREAMS = 4,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic                size_mode,
    input  logic [13:0]         fixed_size,
    input  logic                link_up,
    input  logic                tx_ovfout,
    input  logic                tx_unfout,
    input  logic                tx_axis_tready,
    output logic                tx_axis_tvalid,
    output logic [DATA_W-1:0]   tx_axis_tdata,
    output logic [DATA_W/8-1:0] tx_axis_tkeep,
    output logic                tx_axis_tlast,
    output logic                tx_axis_tuser,
    output logic                busy,
    output logic                done,
    output logic                tx_err,
    output logic [CNT_W-1:0]    pkt_cnt
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ_W  = 14;
    localparam int RM_W  = $clog2(BYTES + 1);
    localparam int SID_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_LINK, S_SEND, S_DONE} state_t;
    state_t r_state, w_next_state;

    logic              r_start_d;
    logic              r_valid;
    logic [SZ_W-1:0]   r_beat;
    logic [SZ_W-1:0]   r_last_beat;
    logic [SZ_W-1:0]   r_sweep;
    logic [RM_W-1:0]   r_rem;
    logic [SID_W-1:0]  r_stream;
    logic [15:0]       r_seq [NUM_STREAMS];
    logic [15:0]       r_burst_cnt;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic              r_tx_err;

    logic              w_start_edge, w_launch, w_is_last, w_acc, w_acc_last;
    logic              w_burst_end, w_pkt_load;
    logic [SZ_W-1:0]   w_fixed_sz, w_new_size, w_new_last_beat;
    logic [RM_W-1:0]   w_new_rem;
    logic [15:0]       w_seq, w_k;
    logic [DATA_W-1:0] w_data;
    logic [BYTES-1:0]  w_keep;

    assign w_start_edge = start & ~r_start_d;
    assign w_launch     = w_start_edge & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_is_last    = (r_beat == r_last_beat);
    assign w_acc        = r_valid & tx_axis_tready;
    assign w_acc_last   = w_acc & w_is_last;
    assign w_burst_end  = ~continuous & (r_burst_cnt == 16'(PKT_NUM - 1));
    assign w_pkt_load   = (r_state == S_SEND) & (~r_valid | (w_acc_last & (w_next_state == S_SEND)));

    assign w_fixed_sz = (fixed_size < SZ_W'(MIN_SIZE)) ? SZ_W'(MIN_SIZE) :
                        (fixed_size > SZ_W'(MAX_SIZE)) ? SZ_W'(MAX_SIZE) : fixed_size;
    assign w_new_size      = size_mode ? r_sweep : w_fixed_sz;
    assign w_new_last_beat = (w_new_size - SZ_W'(1)) / SZ_W'(BYTES);
    assign w_new_rem       = RM_W'(w_new_size - w_new_last_beat * SZ_W'(BYTES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // A packet in flight always completes; exits from SEND happen only on tlast acceptance.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_start_edge) w_next_state = S_WAIT_LINK;
            S_WAIT_LINK: if (link_up)      w_next_state = S_SEND;
            S_SEND: begin
                if (w_acc_last) begin
                    if (stop)             w_next_state = S_IDLE;
                    else if (w_burst_end) w_next_state = S_DONE;
                    else if (!link_up)    w_next_state = S_WAIT_LINK;
                end
            end
            S_DONE:      if (w_start_edge) w_next_state = S_WAIT_LINK;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_d   <= 1'b0;
            r_valid     <= 1'b0;
            r_beat      <= '0;
            r_last_beat <= '0;
            r_sweep     <= SZ_W'(MIN_SIZE);
            r_rem       <= '0;
            r_stream    <= '0;
            r_burst_cnt <= '0;
            r_pkt_cnt   <= '0;
            r_tx_err    <= 1'b0;
            for (int i = 0; i < NUM_STREAMS; i++) r_seq[i] <= '0;
        end else begin
            r_start_d <= start;
            if (tx_ovfout | tx_unfout) r_tx_err <= 1'b1;
            else if (w_launch)         r_tx_err <= 1'b0;
            if (w_launch) begin
                r_pkt_cnt   <= '0;
                r_burst_cnt <= '0;
            end
            if (w_acc) begin
                if (w_is_last) begin
                    r_pkt_cnt       <= r_pkt_cnt + 1'b1;
                    r_burst_cnt     <= r_burst_cnt + 16'd1;
                    r_seq[r_stream] <= r_seq[r_stream] + 16'd1;
                    r_stream        <= (r_stream == SID_W'(NUM_STREAMS - 1)) ? '0 : r_stream + 1'b1;
                    r_beat          <= '0;
                    r_valid         <= 1'b0;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            // Next packet is latched here, overriding the tlast clear so there is no idle gap.
            if (w_pkt_load) begin
                r_valid     <= 1'b1;
                r_beat      <= '0;
                r_last_beat <= w_new_last_beat;
                r_rem       <= w_new_rem;
                if (size_mode)
                    r_sweep <= (r_sweep >= SZ_W'(MAX_SIZE)) ? SZ_W'(MIN_SIZE) : r_sweep + 1'b1;
            end
        end
    end

    assign w_seq = r_seq[r_stream];

    always_comb begin
        w_data = '0;
        w_k    = '0;
        for (int j = 0; j < BYTES; j++) begin
            w_k = 16'(r_beat) * 16'(BYTES) + 16'(j);
            if (w_k == 16'd0)      w_data[8*j +: 8] = 8'(r_stream);
            else if (w_k == 16'd1) w_data[8*j +: 8] = w_seq[15:8];
            else if (w_k == 16'd2) w_data[8*j +: 8] = w_seq[7:0];
            else                   w_data[8*j +: 8] = w_k[7:0];
        end
    end

    // Shifting by BYTES yields zero, so a full last beat still gets all-ones keep.
    assign w_keep = w_is_last ? ~({BYTES{1'b1}} << r_rem) : {BYTES{1'b1}};

    assign tx_axis_tvalid = r_valid;
    assign tx_axis_tdata  = r_valid ? w_data : '0;
    assign tx_axis_tkeep  = r_valid ? w_keep : '0;
    assign tx_axis_tlast  = r_valid & w_is_last;
    assign tx_axis_tuser  = 1'b0;
    assign busy           = (r_state == S_WAIT_LINK) | (r_state == S_SEND);
    assign done           = (r_state == S_DONE);
    assign tx_err         = r_tx_err;
    assign pkt_cnt        = r_pkt_cnt;
endmodule

// File: tb/tb_cmac_usplus_0_axis_multi_pkt_gen.sv
// tb/tb_cmac_usplus_0_axis_multi_pkt_gen.sv - directed bench for the multi-stream AXIS packet generator
// Reference byte pattern and stream/seq/size bookkeeping are computed locally from the packet rules.
module tb_cmac_usplus_0_axis_multi_pkt_gen;
    localparam int DW   = 512;
    localparam int NB   = DW / 8;
    localparam int MINS = 64;
    localparam int MAXS = 130;
    localparam int NS   = 4;
    localparam int PN   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, stop = 1'b0, continuous = 1'b0, size_mode = 1'b0;
    logic [13:0]   fixed_size = 14'd64;
    logic          link_up = 1'b1, tx_ovfout = 1'b0, tx_unfout = 1'b0, tready = 1'b0;
    logic          tvalid, tlast, tuser, busy, done, tx_err;
    logic [DW-1:0] tdata;
    logic [NB-1:0] tkeep;
    logic [31:0]   pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int m_stream;
    int m_sweep;
    int m_seq [NS];

    cmac_usplus_0_axis_multi_pkt_gen #(
        .DATA_W(DW), .PKT_NUM(PN), .MIN_SIZE(MINS), .MAX_SIZE(MAXS), .NUM_STREAMS(NS), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
        .size_mode(size_mode), .fixed_size(fixed_size), .link_up(link_up),
        .tx_ovfout(tx_ovfout), .tx_unfout(tx_unfout), .tx_axis_tready(tready),
        .tx_axis_tvalid(tvalid), .tx_axis_tdata(tdata), .tx_axis_tkeep(tkeep),
        .tx_axis_tlast(tlast), .tx_axis_tuser(tuser), .busy(busy), .done(done),
        .tx_err(tx_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int k, input int s, input int sq);
        if (k == 0)      return s[7:0];
        else if (k == 1) return sq[15:8];
        else if (k == 2) return sq[7:0];
        else             return k[7:0];
    endfunction

    task automatic model_reset();
        m_stream = 0;
        m_sweep  = MINS;
        for (int i = 0; i < NS; i++) m_seq[i] = 0;
    endtask

    // Returns just after the clock edge that accepts the packet's tlast.
    task automatic recv_pkt(input int sz, input int s, input int sq, input bit bp);
        int            nbeats = (sz + NB - 1) / NB;
        int            b = 0;
        int            guard = 0;
        bit            stalled = 1'b0;
        logic [DW-1:0] pd, ed, mask;
        logic [NB-1:0] pk, ek;
        logic          pl;
        while (b < nbeats && guard < 400) begin
            @(negedge clk);
            guard++;
            if (stalled) begin
                chk("stall_valid", DW'(tvalid), DW'(1));
                chk("stall_data", tdata, pd);
                chk("stall_keep", DW'(tkeep), DW'(pk));
                chk("stall_last", DW'(tlast), DW'(pl));
            end
            tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (tvalid) begin
                if (tready) begin
                    ed = '0; mask = '0; ek = '0;
                    for (int j = 0; j < NB; j++) begin
                        if (b * NB + j < sz) begin
                            mask[8*j +: 8] = 8'hff;
                            ek[j] = 1'b1;
                            ed[8*j +: 8] = pbyte(b * NB + j, s, sq);
                        end
                    end
                    chk("beat_data", tdata & mask, ed);
                    chk("beat_keep", DW'(tkeep), DW'(ek));
                    chk("beat_last", DW'(tlast), DW'(b == nbeats - 1));
                    b++;
                end else begin
                    stalled = 1'b1;
                    pd = tdata; pk = tkeep; pl = tlast;
                end
            end
        end
        if (b < nbeats) chk("pkt_timeout", DW'(b), DW'(nbeats));
        @(posedge clk);
        #1;
        tready = 1'b0;
    endtask

    task automatic next_pkt(input bit bp);
        int sz;
        if (size_mode) begin
            sz = m_sweep;
            m_sweep = (m_sweep == MAXS) ? MINS : m_sweep + 1;
        end else begin
            sz = (int'(fixed_size) < MINS) ? MINS : (int'(fixed_size) > MAXS) ? MAXS : int'(fixed_size);
        end
        recv_pkt(sz, m_stream, m_seq[m_stream], bp);
        m_seq[m_stream] = (m_seq[m_stream] + 1) & 16'hffff;
        m_stream = (m_stream + 1) % NS;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("done", DW'(done), DW'(1));
        chk("done_busy", DW'(busy), DW'(0));
        chk("done_cnt", DW'(pkt_cnt), DW'(PN));
    endtask

    task automatic fixed_burst(input logic [13:0] fs);
        fixed_size = fs;
        pulse_start();
        repeat (PN) next_pkt(1'b0);
        wait_done();
    endtask

    initial begin
        int g;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", DW'(tvalid), DW'(0));
        chk("rst_data", tdata, '0);
        chk("rst_keep", DW'(tkeep), DW'(0));
        chk("rst_last", DW'(tlast), DW'(0));
        chk("rst_user", DW'(tuser), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_err", DW'(tx_err), DW'(0));
        chk("rst_cnt", DW'(pkt_cnt), DW'(0));
        reset = 1'b0;

        fixed_burst(14'd64);
        fixed_burst(14'd65);
        fixed_burst(14'd10);
        fixed_burst(14'd200);

        size_mode  = 1'b1;
        continuous = 1'b1;
        pulse_start();
        repeat (MAXS - MINS + 1) next_pkt(1'b0);
        stop = 1'b1;
        next_pkt(1'b0);
        stop = 1'b0;
        chk("sweep_busy", DW'(busy), DW'(0));
        chk("sweep_done", DW'(done), DW'(0));
        chk("sweep_cnt", DW'(pkt_cnt), DW'(MAXS - MINS + 2));

        pulse_start();
        repeat (499) next_pkt(1'b1);
        stop = 1'b1;
        next_pkt(1'b1);
        stop = 1'b0;
        chk("bp_cnt", DW'(pkt_cnt), DW'(500));
        chk("bp_busy", DW'(busy), DW'(0));

        size_mode  = 1'b0;
        fixed_size = 14'd130;
        pulse_start();
        next_pkt(1'b0);
        link_up = 1'b0;
        next_pkt(1'b0);
        repeat (8) @(negedge clk);
        chk("link_valid", DW'(tvalid), DW'(0));
        chk("link_busy", DW'(busy), DW'(1));
        link_up = 1'b1;
        next_pkt(1'b0);
        stop = 1'b1;
        next_pkt(1'b0);
        stop = 1'b0;
        chk("link_idle", DW'(busy), DW'(0));
        chk("link_cnt", DW'(pkt_cnt), DW'(4));

        continuous = 1'b0;
        @(negedge clk);
        tx_unfout = 1'b1;
        @(negedge clk);
        tx_unfout = 1'b0;
        chk("unf_set", DW'(tx_err), DW'(1));
        repeat (5) @(negedge clk);
        chk("unf_sticky", DW'(tx_err), DW'(1));
        fixed_size = 14'd64;
        pulse_start();
        chk("err_clear", DW'(tx_err), DW'(0));
        repeat (PN) next_pkt(1'b0);
        wait_done();

        @(negedge clk);
        start = 1'b1;
        tx_ovfout = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tx_ovfout = 1'b0;
        chk("ovf_set_wins", DW'(tx_err), DW'(1));
        repeat (PN) next_pkt(1'b0);
        wait_done();
        chk("ovf_kept", DW'(tx_err), DW'(1));

        continuous = 1'b1;
        fixed_size = 14'd130;
        pulse_start();
        g = 0;
        while (!tvalid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("pre_rst_valid", DW'(tvalid), DW'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", DW'(tvalid), DW'(0));
        chk("mid_rst_data", tdata, '0);
        chk("mid_rst_keep", DW'(tkeep), DW'(0));
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_err", DW'(tx_err), DW'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        continuous = 1'b0;
        fixed_burst(14'd64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
